// File: rtl/sqrt_fixed_pkg.sv
// Shared types and width helpers for the fixed-point square-root unit.
// Widths are derived from the operand format and digits-per-cycle.
package sqrt_fixed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Radicand width: in * 2^FL, padded to an even number of bits.
  function automatic int radw_of(input int il, input int fl);
    return ((il + 2 * fl + 1) / 2) * 2;
  endfunction

  function automatic int rw_of(input int il, input int fl);
    return radw_of(il, fl) / 2;
  endfunction

  function automatic int k_of(input int il, input int fl, input int bpc);
    return (rw_of(il, fl) + bpc - 1) / bpc;
  endfunction

  function automatic int cnt_w_of(input int il, input int fl, input int bpc);
    return $clog2(k_of(il, fl, bpc) + 1);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One combinational restoring square-root step: consumes one radicand bit
// pair and resolves one root bit.
module sqrt_step #(
  parameter int RW = 16
) (
  input  logic [RW+1:0] rem,
  input  logic [RW-1:0] root,
  input  logic [1:0]    pair,
  output logic [RW+1:0] next_rem,
  output logic [RW-1:0] next_root
);

  logic [RW+4:0] trial;
  logic          unused_bits;

  // Extra top bit holds the borrow, i.e. the sign of the trial subtraction.
  assign trial = {1'b0, rem, pair} - {3'b000, root, 2'b01};

  always_comb begin
    if (!trial[RW+4]) begin
      next_rem  = trial[RW+1:0];
      next_root = {root[RW-2:0], 1'b1};
    end else begin
      next_rem  = {rem[RW-1:0], pair};
      next_root = {root[RW-2:0], 1'b0};
    end
  end

  // Remainder is bounded by 2*root, so these bits are always zero.
  assign unused_bits = ^{trial[RW+3:RW+2], root[RW-1]};

endmodule

// File: rtl/sqrt_fixed_pipe.sv
// Fixed-point square root of a signed Q(IL.FL) operand with valid/ready on
// both sides; BPC restoring steps per BUSY cycle, optional round-to-nearest.
module sqrt_fixed_pipe
  import sqrt_fixed_pkg::*;
#(
  parameter int IL    = 8,
  parameter int FL    = 12,
  parameter int BPC   = 1,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IL+FL-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IL+FL-1:0] out,
  output logic             err,
  output logic [1:0]       state
);

  localparam int OW  = IL + FL;
  localparam int RW  = rw_of(IL, FL);
  localparam int K   = k_of(IL, FL, BPC);
  localparam int CW  = cnt_w_of(IL, FL, BPC);
  localparam int SRW = 2 * BPC * K;

  state_t          state_q, state_d;
  logic [SRW-1:0]  shreg_q;
  logic [RW-1:0]   root_q;
  logic [RW+1:0]   rem_q;
  logic [CW-1:0]   cnt_q;
  logic [OW-1:0]   out_q;
  logic            err_q;

  logic            accept, last, round_up;
  logic [RW-1:0]   result;
  logic [RW+1:0]   rem_c  [BPC+1];
  logic [RW-1:0]   root_c [BPC+1];

  assign accept = in_valid && (state_q == IDLE);
  assign last   = (state_q == BUSY) && (cnt_q == CW'(1));

  // Step chain: MSB radicand pair feeds the first step.
  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;
  for (genvar j = 0; j < BPC; j++) begin : g_step
    sqrt_step #(.RW(RW)) u_step (
      .rem       (rem_c[j]),
      .root      (root_c[j]),
      .pair      (shreg_q[SRW-1-2*j -: 2]),
      .next_rem  (rem_c[j+1]),
      .next_root (root_c[j+1])
    );
  end

  assign round_up = (ROUND != 0) && (rem_c[BPC] > {2'b00, root_c[BPC]});
  assign result   = root_c[BPC] + RW'(round_up);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = in[OW-1] ? DONE : BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    state     = state_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      shreg_q <= SRW'({in, {FL{1'b0}}});
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= CW'(K);
      if (in[OW-1]) begin
        out_q <= '0;
        err_q <= 1'b1;
      end
    end else if (state_q == BUSY) begin
      shreg_q <= shreg_q << (2 * BPC);
      root_q  <= root_c[BPC];
      rem_q   <= rem_c[BPC];
      cnt_q   <= cnt_q - CW'(1);
      if (last) begin
        out_q <= OW'(result);
        err_q <= 1'b0;
      end
    end
  end

  assign out = out_q;
  assign err = err_q;

endmodule

// File: tb/tb_sqrt_fixed_pipe.sv
// Directed bench: a BPC=1 truncating unit and a BPC=4 rounding unit driven
// side by side with hand-computed roots, latencies and handshake behaviour.
module tb_sqrt_fixed_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [19:0] in;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, err_a;
  logic [19:0] out_a;
  logic [1:0]  state_a;
  logic        in_ready_b, out_valid_b, err_b;
  logic [19:0] out_b;
  logic [1:0]  state_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sqrt_fixed_pipe #(.IL(8), .FL(12), .BPC(1), .ROUND(0)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in(in), .out_valid(out_valid_a), .out_ready(out_ready), .out(out_a),
    .err(err_a), .state(state_a)
  );

  sqrt_fixed_pipe #(.IL(8), .FL(12), .BPC(4), .ROUND(1)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in(in), .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b),
    .err(err_b), .state(state_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept x on both units, measure latency to out_valid, check the result,
  // optionally stall in DONE, then hand the result off and check return to IDLE.
  task automatic run_op(input logic [19:0] x, input logic [19:0] ea, input logic [19:0] eb,
                        input logic ee, input int la, input int lb, input int stall);
    int na, nb, n;
    @(negedge clk);
    in        = x;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check("in_ready_a", 32'(in_ready_a), 1);
    check("in_ready_b", 32'(in_ready_b), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    na = 0; nb = 0; n = 0;
    while ((na == 0 || nb == 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (na == 0 && out_valid_a) na = n;
      if (nb == 0 && out_valid_b) nb = n;
    end
    check("latency_a", 32'(na), 32'(la));
    check("latency_b", 32'(nb), 32'(lb));
    check("out_a", 32'(out_a), 32'(ea));
    check("out_b", 32'(out_b), 32'(eb));
    check("err_a", 32'(err_a), 32'(ee));
    check("err_b", 32'(err_b), 32'(ee));
    check("done_state_a", 32'(state_a), 2);
    check("done_in_ready_a", 32'(in_ready_a), 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in       = 20'h00400;
      @(posedge clk); #1;
      check("stall_out_a", 32'(out_a), 32'(ea));
      check("stall_out_b", 32'(out_b), 32'(eb));
      check("stall_err_a", 32'(err_a), 32'(ee));
      check("stall_valid_a", 32'(out_valid_a), 1);
      check("stall_valid_b", 32'(out_valid_b), 1);
      check("stall_in_ready_a", 32'(in_ready_a), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_state_a", 32'(state_a), 0);
    check("idle_state_b", 32'(state_b), 0);
    check("idle_valid_a", 32'(out_valid_a), 0);
    check("idle_hold_out_a", 32'(out_a), 32'(ea));
    check("idle_hold_out_b", 32'(out_b), 32'(eb));
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in        = '0;
    out_ready = 1'b0;
    #12;
    check("rst_state_a", 32'(state_a), 0);
    check("rst_state_b", 32'(state_b), 0);
    check("rst_in_ready_a", 32'(in_ready_a), 1);
    check("rst_out_valid_a", 32'(out_valid_a), 0);
    check("rst_out_a", 32'(out_a), 0);
    check("rst_err_a", 32'(err_a), 0);
    check("rst_out_b", 32'(out_b), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 4.0 -> 2.0 exactly; no rounding on the exact square.
    run_op(20'd16384, 20'd8192, 20'd8192, 1'b0, 16, 4, 0);
    // 2.0 -> 5792 truncated, 5793 rounded (final rem 7168 > 5792).
    run_op(20'd8192, 20'd5792, 20'd5793, 1'b0, 16, 4, 0);
    // Largest positive operand.
    run_op(20'h7FFFF, 20'd46340, 20'd46341, 1'b0, 16, 4, 0);
    // -1 LSB: error path, one-cycle latency.
    run_op(20'hFFFFF, 20'd0, 20'd0, 1'b1, 1, 1, 0);
    // Zero after an error clears err.
    run_op(20'd0, 20'd0, 20'd0, 1'b0, 16, 4, 0);
    // Ten-cycle stall in DONE with in_valid pulses.
    run_op(20'd16384, 20'd8192, 20'd8192, 1'b0, 16, 4, 10);

    // Asynchronous reset during cycle 7 of 16 of BUSY.
    @(negedge clk);
    in       = 20'd16384;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre_rst_busy_a", 32'(state_a), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_state_a", 32'(state_a), 0);
    check("mid_rst_state_b", 32'(state_b), 0);
    check("mid_rst_out_a", 32'(out_a), 0);
    check("mid_rst_out_b", 32'(out_b), 0);
    check("mid_rst_valid_a", 32'(out_valid_a), 0);
    check("mid_rst_valid_b", 32'(out_valid_b), 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(20'd16384, 20'd8192, 20'd8192, 1'b0, 16, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
